point_adder_seq: RTL and testbench



---
 rtl/point_adder_seq_pkg.sv | 34 +++
 rtl/point_adder_seq_if.sv | 35 +++
 rtl/point_adder_seq_mod_mul.sv | 64 ++++++
 rtl/point_adder_seq.sv | 207 ++++++++++++++++++++
 tb/tb_point_adder_seq.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/point_adder_seq_pkg.sv
// Shared definitions for the sequential elliptic-curve point adder.
// Holds the default coordinate width, the default small test curve
// y^2 = x^3 + 2x + 2 over GF(17), and the controller state encoding.
// There are no ports; the package is imported by the interface and modules.

`ifndef DATAWIDTH
`define DATAWIDTH 5
`endif

package point_adder_seq_pkg;

    localparam int DATAWIDTH   = `DATAWIDTH;
    localparam int DEF_MOD_P   = 17;
    localparam int DEF_CURVE_A = 2;
    localparam int DEF_CURVE_B = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLASSIFY,
        ST_NUM,
        ST_DEN,
        ST_INV,
        ST_LAM,
        ST_LSQ,
        ST_RY,
        ST_FIN
    } state_t;

    // Worst-case cycles from the start-capturing edge to done on the full path.
    function automatic int latency_bound(input int width);
        return 8 * width + 16;
    endfunction

endpackage

// File: rtl/point_adder_seq_if.sv
// Request/result bundle of the point adder.
// Handshake: the requester pulses start for one cycle while busy is low; the
// operands are sampled on that edge only.  busy rises on the next cycle and
// falls in the same cycle that done pulses for exactly one cycle.  Rx_out,
// Ry_out and R_inf are valid from done and hold until the next done.
// Signals: start, Px, Py, P_inf, Qx, Qy, Q_inf (requester -> adder);
//          busy, done, Rx_out, Ry_out, R_inf, dbg_state (adder -> requester).

interface point_adder_seq_if #(
    parameter int WIDTH = point_adder_seq_pkg::DATAWIDTH
);
    logic                        start;
    logic [WIDTH-1:0]            Px;
    logic [WIDTH-1:0]            Py;
    logic                        P_inf;
    logic [WIDTH-1:0]            Qx;
    logic [WIDTH-1:0]            Qy;
    logic                        Q_inf;
    logic                        busy;
    logic                        done;
    logic [WIDTH-1:0]            Rx_out;
    logic [WIDTH-1:0]            Ry_out;
    logic                        R_inf;
    point_adder_seq_pkg::state_t dbg_state;

    modport master (
        output start, Px, Py, P_inf, Qx, Qy, Q_inf,
        input  busy, done, Rx_out, Ry_out, R_inf, dbg_state
    );

    modport slave (
        input  start, Px, Py, P_inf, Qx, Qy, Q_inf,
        output busy, done, Rx_out, Ry_out, R_inf, dbg_state
    );
endinterface

// File: rtl/point_adder_seq_mod_mul.sv
// mod_mul_seq: sequential modular multiplier p = a*b mod MOD_P.
// MSB-first shift-add: the edge that sees start loads the operands, then
// WIDTH iteration cycles each double the accumulator and conditionally add a,
// reducing after each step.  done pulses one cycle with p valid.
// Ports: clk, rst (sync, active-high), start, a, b (both < MOD_P), done, p.

module mod_mul_seq #(
    parameter int WIDTH = 5,
    parameter int MOD_P = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] p
);
    localparam int             CW    = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] P_EXT = (WIDTH + 1)'(MOD_P);

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH:0]   dbl_v;
    logic [WIDTH:0]   add_v;

    // Both partial sums stay below 2*MOD_P, so one extra bit suffices.
    always_comb begin
        dbl_v = {p, 1'b0};
        if (dbl_v >= P_EXT) dbl_v = dbl_v - P_EXT;
        add_v = dbl_v + (b_r[WIDTH-1] ? {1'b0, a_r} : '0);
        if (add_v >= P_EXT) add_v = add_v - P_EXT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
            p    <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_r <= a;
                b_r <= b;
                p   <= '0;
                cnt <= CW'(WIDTH);
                run <= 1'b1;
            end else if (run) begin
                p   <= add_v[WIDTH-1:0];
                b_r <= b_r << 1;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/point_adder_seq.sv
// point_adder_seq: multi-cycle affine point adder R = P + Q on
// y^2 = x^3 + CURVE_A*x + b over GF(MOD_P), with doubling and infinity cases.
// One shared sequential multiplier serves the slope numerator square, the
// slope product, its square and the y product; the inverse is a binary
// extended Euclid run inline in the INV state.
// Ports: clk, rst (sync, active-high), bus (point_adder_seq_if.slave).

module point_adder_seq
    import point_adder_seq_pkg::*;
#(
    parameter int WIDTH   = DATAWIDTH,
    parameter int MOD_P   = DEF_MOD_P,
    parameter int CURVE_A = DEF_CURVE_A
) (
    input  logic             clk,
    input  logic             rst,
    point_adder_seq_if.slave bus
);
    localparam logic [WIDTH:0]   P_EXT = (WIDTH + 1)'(MOD_P);
    localparam logic [WIDTH-1:0] A_RED = WIDTH'(CURVE_A % MOD_P);

    state_t           state;
    logic [WIDTH-1:0] px, py, qx, qy;
    logic             p_inf, q_inf, dbl, inf_w;
    logic [WIDTH-1:0] num, den, lam, rx_w, ry_w;
    logic [WIDTH-1:0] u, v, x1, x2;
    logic             mul_wait, mul_go, mul_done, mul_state;
    logic [WIDTH-1:0] mul_a, mul_b, mul_p;

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= P_EXT) s = s - P_EXT;
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b) d = d + P_EXT;
        return d[WIDTH-1:0];
    endfunction

    // x/2 mod p: odd values are made even by adding p before the shift.
    function automatic logic [WIDTH-1:0] mod_half(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] s;
        s = {1'b0, x};
        if (x[0]) s = s + P_EXT;
        return s[WIDTH:1];
    endfunction

    // Multiply operands are chosen by state; a multiply is launched on the
    // first cycle of each multiplying state and consumed when done returns.
    always_comb begin
        mul_state = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        case (state)
            ST_NUM: begin mul_state = dbl;  mul_a = px;  mul_b = px;  end
            ST_LAM: begin mul_state = 1'b1; mul_a = num; mul_b = den; end
            ST_LSQ: begin mul_state = 1'b1; mul_a = lam; mul_b = lam; end
            ST_RY:  begin mul_state = 1'b1; mul_a = lam; mul_b = mod_sub(px, rx_w); end
            default: ;
        endcase
        mul_go = mul_state && !mul_wait;
    end

    mod_mul_seq #(.WIDTH(WIDTH), .MOD_P(MOD_P)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_go),
        .a     (mul_a),
        .b     (mul_b),
        .done  (mul_done),
        .p     (mul_p)
    );

    assign bus.dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.Rx_out <= '0;
            bus.Ry_out <= '0;
            bus.R_inf  <= 1'b0;
            {px, py, qx, qy} <= '0;
            {p_inf, q_inf, dbl, inf_w} <= '0;
            {num, den, lam, rx_w, ry_w} <= '0;
            {u, v, x1, x2} <= '0;
            mul_wait   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (mul_go) mul_wait <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        px       <= bus.Px;
                        py       <= bus.Py;
                        p_inf    <= bus.P_inf;
                        qx       <= bus.Qx;
                        qy       <= bus.Qy;
                        q_inf    <= bus.Q_inf;
                        dbl      <= 1'b0;
                        inf_w    <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= ST_CLASSIFY;
                    end
                end
                ST_CLASSIFY: begin
                    if (p_inf) begin
                        inf_w <= q_inf;
                        rx_w  <= q_inf ? '0 : qx;
                        ry_w  <= q_inf ? '0 : qy;
                        state <= ST_FIN;
                    end else if (q_inf) begin
                        rx_w  <= px;
                        ry_w  <= py;
                        state <= ST_FIN;
                    end else if (px == qx && (py != qy || py == '0)) begin
                        // P == -Q, or a point of order two being doubled.
                        inf_w <= 1'b1;
                        rx_w  <= '0;
                        ry_w  <= '0;
                        state <= ST_FIN;
                    end else begin
                        dbl   <= (px == qx);
                        state <= ST_NUM;
                    end
                end
                ST_NUM: begin
                    if (!dbl) begin
                        num   <= mod_sub(qy, py);
                        state <= ST_DEN;
                    end else if (mul_wait && mul_done) begin
                        num      <= mod_add(mod_add(mod_add(mul_p, mul_p), mul_p), A_RED);
                        mul_wait <= 1'b0;
                        state    <= ST_DEN;
                    end
                end
                ST_DEN: begin
                    // Invariants for the inverse: x1*den == u, x2*den == v (mod p).
                    u     <= dbl ? mod_add(py, py) : mod_sub(qx, px);
                    v     <= WIDTH'(MOD_P);
                    x1    <= WIDTH'(1);
                    x2    <= '0;
                    state <= ST_INV;
                end
                ST_INV: begin
                    if (u == WIDTH'(1)) begin
                        den   <= x1;
                        state <= ST_LAM;
                    end else if (v == WIDTH'(1)) begin
                        den   <= x2;
                        state <= ST_LAM;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        x1 <= mod_half(x1);
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        x2 <= mod_half(x2);
                    end else if (u >= v) begin
                        u  <= u - v;
                        x1 <= mod_sub(x1, x2);
                    end else begin
                        v  <= v - u;
                        x2 <= mod_sub(x2, x1);
                    end
                end
                ST_LAM: begin
                    if (mul_wait && mul_done) begin
                        lam      <= mul_p;
                        mul_wait <= 1'b0;
                        state    <= ST_LSQ;
                    end
                end
                ST_LSQ: begin
                    if (mul_wait && mul_done) begin
                        // For doubling qx equals px, so one formula covers both.
                        rx_w     <= mod_sub(mod_sub(mul_p, px), qx);
                        mul_wait <= 1'b0;
                        state    <= ST_RY;
                    end
                end
                ST_RY: begin
                    if (mul_wait && mul_done) begin
                        ry_w     <= mod_sub(mul_p, py);
                        mul_wait <= 1'b0;
                        state    <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    bus.Rx_out <= rx_w;
                    bus.Ry_out <= ry_w;
                    bus.R_inf  <= inf_w;
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_point_adder_seq.sv
// Self-checking bench for point_adder_seq on y^2 = x^3 + 2x + 2 over GF(17).
// A plain-integer affine point-addition model (Fermat inverse) supplies the
// expected results; a negedge compare process checks every done pulse.

module tb_point_adder_seq;
    import point_adder_seq_pkg::*;

    localparam int W     = 5;
    localparam int P     = 17;
    localparam int A     = 2;
    localparam int ORD   = 19;
    localparam int EW    = 2 * W + 1;
    localparam int BOUND = 8 * W + 16;

    typedef struct {
        int x;
        int y;
        bit inf;
    } pt_t;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] cmp_e;
    pt_t  mult[ORD];

    point_adder_seq_if #(.WIDTH(W)) bus ();

    point_adder_seq #(.WIDTH(W), .MOD_P(P), .CURVE_A(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic int md(input int val);
        return ((val % P) + P) % P;
    endfunction

    function automatic int inv(input int val);
        int r;
        r = 1;
        for (int i = 0; i < P - 2; i++) r = md(r * val);
        return r;
    endfunction

    function automatic pt_t ec_add(input pt_t a, input pt_t b);
        pt_t r;
        int  lam;
        r.x = 0; r.y = 0; r.inf = 1'b0;
        if (a.inf) return b;
        if (b.inf) return a;
        if (a.x == b.x && (a.y != b.y || a.y == 0)) begin
            r.inf = 1'b1;
            return r;
        end
        if (a.x == b.x) lam = md((3 * a.x * a.x + A) * inv(2 * a.y));
        else            lam = md((b.y - a.y) * inv(b.x - a.x));
        r.x = md(lam * lam - a.x - b.x);
        r.y = md(lam * (a.x - r.x) - a.y);
        return r;
    endfunction

    function automatic pt_t mk(input int x, input int y, input bit inf);
        pt_t r;
        r.x = x; r.y = y; r.inf = inf;
        return r;
    endfunction

    function automatic logic [EW-1:0] pack(input pt_t r);
        return {r.inf, W'(r.x), W'(r.y)};
    endfunction

    task automatic chk(input string name, input int act, input int req);
        tests_run++;
        if (act != req) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            chk("done_pending", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                cmp_e = exp_q.pop_front();
                chk("r_inf", int'(bus.R_inf), int'(cmp_e[EW-1]));
                if (!cmp_e[EW-1]) begin
                    chk("rx", int'(bus.Rx_out), int'(cmp_e[2*W-1:W]));
                    chk("ry", int'(bus.Ry_out), int'(cmp_e[W-1:0]));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive_ops(input pt_t p, input pt_t q);
        bus.Px    = W'(p.inf ? $urandom_range(0, P - 1) : p.x);
        bus.Py    = W'(p.inf ? $urandom_range(0, P - 1) : p.y);
        bus.P_inf = p.inf;
        bus.Qx    = W'(q.inf ? $urandom_range(0, P - 1) : q.x);
        bus.Qy    = W'(q.inf ? $urandom_range(0, P - 1) : q.y);
        bus.Q_inf = q.inf;
    endtask

    task automatic run_op(input pt_t p, input pt_t q, input pt_t e,
                          input bit repulse, output int lat);
        @(negedge clk);
        drive_ops(p, q);
        bus.start = 1'b1;
        exp_q.push_back(pack(e));
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < BOUND + 4) begin
            @(negedge clk);
            lat++;
            if (repulse && lat == 4) begin
                drive_ops(mk(6, 3, 1'b0), mk(10, 6, 1'b0));
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("latency_bound", int'(lat <= BOUND), 1);
        if (!bus.done) begin
            chk("done_timeout", 0, 1);
            exp_q.delete();
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end else begin
            @(negedge clk);
            chk("done_one_cycle", int'(bus.done), 0);
            chk("busy_after_done", int'(bus.busy), 0);
            chk("hold_inf", int'(bus.R_inf), int'(e.inf));
            if (!e.inf) begin
                chk("hold_rx", int'(bus.Rx_out), e.x);
                chk("hold_ry", int'(bus.Ry_out), e.y);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  lat;
        int  ia, ib;
        pt_t g, pa, pb;

        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.Px = '0; bus.Py = '0; bus.P_inf = 1'b0;
        bus.Qx = '0; bus.Qy = '0; bus.Q_inf = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_rx", int'(bus.Rx_out), 0);
        chk("reset_ry", int'(bus.Ry_out), 0);
        chk("reset_inf", int'(bus.R_inf), 0);

        // Multiples of the generator, pinned by hand-computed points.
        g = mk(5, 1, 1'b0);
        mult[0] = mk(0, 0, 1'b1);
        for (int k = 1; k < ORD; k++) mult[k] = ec_add(mult[k-1], g);
        chk("model_2p_x", mult[2].x, 6);
        chk("model_2p_y", mult[2].y, 3);
        chk("model_3p_x", mult[3].x, 10);
        chk("model_3p_y", mult[3].y, 6);
        pa = ec_add(mult[ORD-1], g);
        chk("model_order", int'(pa.inf), 1);

        // Directed cases.
        run_op(mk(5, 1, 0), mk(6, 3, 0), mk(10, 6, 0), 1'b0, lat);
        run_op(mk(5, 1, 0), mk(5, 1, 0), mk(6, 3, 0), 1'b1, lat);
        run_op(mk(5, 1, 0), mk(5, 16, 0), mk(0, 0, 1), 1'b0, lat);
        chk("inverse_pair_latency", lat, 3);
        run_op(mk(0, 0, 1), mk(10, 6, 0), mk(10, 6, 0), 1'b0, lat);
        chk("p_inf_latency", lat, 3);
        run_op(mk(6, 3, 0), mk(0, 0, 1), mk(6, 3, 0), 1'b0, lat);

        // Re-pulsed start while busy, then reset mid-operation.
        @(negedge clk);
        drive_ops(mk(5, 1, 0), mk(6, 3, 0));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        drive_ops(mk(0, 0, 1), mk(5, 1, 0));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_during_repulse", int'(bus.busy), 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_rx", int'(bus.Rx_out), 0);
        chk("abort_ry", int'(bus.Ry_out), 0);
        chk("abort_inf", int'(bus.R_inf), 0);
        repeat (BOUND + 8) @(negedge clk);
        chk("abort_idle", int'(bus.busy), 0);

        run_op(mk(5, 1, 0), mk(6, 3, 0), mk(10, 6, 0), 1'b0, lat);

        // Random multiples aP + bP against (a+b)P.
        for (int n = 0; n < 200; n++) begin
            ia = $urandom_range(0, ORD - 1);
            ib = $urandom_range(0, ORD - 1);
            pa = mult[ia];
            pb = mult[ib];
            run_op(pa, pb, mult[(ia + ib) % ORD], ($urandom_range(0, 7) == 0), lat);
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
